// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, presents it as the instruction-memory address and captures the
// returned word plus PC+4 into IF/ID, honouring stall, flush and redirect.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating stall/flush/redirect counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        PCWrite,
   input  logic        DecodeRegWrite,
   input  logic        FlushControl,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   output logic [31:0] InstrAddr,
   input  logic [31:0] InstrData,
   output logic [31:0] IFID_Instruction,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] StallCount,
   output logic [31:0] FlushCount,
   output logic [31:0] RedirectCount,
`endif
   output logic [1:0]  FetchState
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_BOOT     = 2'd0,
      S_RUN      = 2'd1,
      S_STALL    = 2'd2,
      S_REDIRECT = 2'd3
   } fetch_state_e;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
   logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic [XLEN-1:0] pc_plus4;
   logic            redirect_ok;

`ifdef FETCH_PERF_CNT_EN
   logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
   logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;
   logic [XLEN-1:0] redir_cnt_q, redir_cnt_d;
`endif

   // Low target bits are forced to zero, so they are intentionally dropped.
   logic unused_target_bits;
   assign unused_target_bits = ^RedirectTarget[1:0];

   // Next-state, PC and IF/ID selection; BOOT holds everything for one edge.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      pc_plus4     = pc_q + XLEN'(4);
      redirect_ok  = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      redir_cnt_d  = redir_cnt_q;
`endif

      case (state_q)
         S_BOOT: begin
            state_d = S_RUN;
         end
         default: begin
            redirect_ok = PCWrite & Redirect;

            // PC: stall beats redirect beats sequential advance
            if (!PCWrite) begin
               pc_d = pc_q;
            end else if (Redirect) begin
               pc_d = {RedirectTarget[31:2], 2'b00};
            end else begin
               pc_d = pc_plus4;
            end

            // IF/ID: flush beats hold; a taken redirect squashes the wrong-path fetch
            if (FlushControl) begin
               ifid_instr_d = NOP_WORD;
               ifid_pc4_d   = '0;
               ifid_valid_d = 1'b0;
            end else if (!DecodeRegWrite) begin
               ifid_instr_d = ifid_instr_q;
               ifid_pc4_d   = ifid_pc4_q;
               ifid_valid_d = ifid_valid_q;
            end else if (redirect_ok) begin
               ifid_instr_d = NOP_WORD;
               ifid_pc4_d   = '0;
               ifid_valid_d = 1'b0;
            end else begin
               ifid_instr_d = InstrData;
               ifid_pc4_d   = pc_plus4;
               ifid_valid_d = 1'b1;
            end

            if (redirect_ok) begin
               state_d = S_REDIRECT;
            end else if (!PCWrite) begin
               state_d = S_STALL;
            end else begin
               state_d = S_RUN;
            end

`ifdef FETCH_PERF_CNT_EN
            if (!PCWrite && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + XLEN'(1);
            if (FlushControl && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + XLEN'(1);
            if (redirect_ok && (redir_cnt_q != CNT_MAX)) redir_cnt_d = redir_cnt_q + XLEN'(1);
`endif
         end
      endcase
   end

   // State, PC and IF/ID registers with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q      <= S_BOOT;
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP_WORD;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         redir_cnt_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
`ifdef FETCH_PERF_CNT_EN
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         redir_cnt_q  <= redir_cnt_d;
`endif
      end
   end

   assign InstrAddr        = pc_q;
   assign IFID_Instruction = ifid_instr_q;
   assign IFID_PCPlus4     = ifid_pc4_q;
   assign IFID_Valid       = ifid_valid_q;
   assign FetchState       = state_q;
`ifdef FETCH_PERF_CNT_EN
   assign StallCount       = stall_cnt_q;
   assign FlushCount       = flush_cnt_q;
   assign RedirectCount    = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, compared every edge against a behavioural model of the fetch rules.
// Honours FETCH_PERF_CNT_EN to also check the performance counters.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write, decode_reg_write, flush, redirect;
   logic [31:0] redirect_target;
   logic [31:0] instr_addr, instr_data;
   logic [31:0] ifid_instr, ifid_pc4;
   logic        ifid_valid;
   logic [1:0]  fetch_state;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_count, flush_count, redirect_count;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] scramble = 32'h0;

   // Model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int          m_state;
   longint      m_stall, m_flush, m_redir;

   always #5 clk = ~clk;

   // Combinational memory: data is the address, optionally scrambled
   assign instr_data = instr_addr ^ scramble;

   fetch_unit dut (
      .Clk              (clk),
      .Reset            (rst_n),
      .PCWrite          (pc_write),
      .DecodeRegWrite   (decode_reg_write),
      .FlushControl     (flush),
      .Redirect         (redirect),
      .RedirectTarget   (redirect_target),
      .InstrAddr        (instr_addr),
      .InstrData        (instr_data),
      .IFID_Instruction (ifid_instr),
      .IFID_PCPlus4     (ifid_pc4),
      .IFID_Valid       (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
      .StallCount       (stall_count),
      .FlushCount       (flush_count),
      .RedirectCount    (redirect_count),
`endif
      .FetchState       (fetch_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat_u32(input longint v);
      return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   // Behavioural rules for one rising edge, applied to the model
   task automatic model_edge();
      logic        taken;
      logic [31:0] next_seq;
      if (!rst_n) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_state = 0; m_stall = 0; m_flush = 0; m_redir = 0;
         return;
      end
      if (m_state == 0) begin
         m_state = 1;
         return;
      end
      taken    = pc_write && redirect;
      next_seq = m_pc + 32'd4;
      if (!pc_write) m_stall++;
      if (flush)     m_flush++;
      if (taken)     m_redir++;
      if (flush || (decode_reg_write && taken)) begin
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (decode_reg_write) begin
         m_instr = m_pc ^ scramble; m_pc4 = next_seq; m_valid = 1'b1;
      end
      if (taken)         m_pc = redirect_target & 32'hFFFF_FFFC;
      else if (pc_write) m_pc = next_seq;
      m_state = taken ? 3 : (pc_write ? 1 : 2);
   endtask

   task automatic check_all();
      check("addr",  instr_addr, m_pc);
      check("instr", ifid_instr, m_instr);
      check("pc4",   ifid_pc4,   m_pc4);
      check("valid", 32'(ifid_valid),  32'(m_valid));
      check("state", 32'(fetch_state), 32'(m_state));
`ifdef FETCH_PERF_CNT_EN
      check("stall_cnt", stall_count,    sat_u32(m_stall));
      check("flush_cnt", flush_count,    sat_u32(m_flush));
      check("redir_cnt", redirect_count, sat_u32(m_redir));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic set_in(input logic pcw, input logic drw, input logic fl,
                         input logic rd, input logic [31:0] tgt);
      pc_write = pcw; decode_reg_write = drw; flush = fl;
      redirect = rd; redirect_target = tgt;
   endtask

   task automatic run_to(input logic [31:0] target, input string tag);
      for (int i = 0; i < 64 && instr_addr != target; i++) step();
      check(tag, instr_addr, target);
   endtask

   initial begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_state = 0; m_stall = 0; m_flush = 0; m_redir = 0;
      rst_n = 1'b0;
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

      // Reset for three edges, then the BOOT cycle and first fetches
      repeat (3) step();
      check("rst_state", 32'(fetch_state), 32'd0);
      check("rst_valid", 32'(ifid_valid), 32'd0);
      rst_n = 1'b1;
      step();
      check("boot_addr", instr_addr, 32'h0);
      check("boot_valid", 32'(ifid_valid), 32'd0);
      step();
      check("f0_instr", ifid_instr, 32'h0);
      check("f0_pc4", ifid_pc4, 32'h4);
      check("f0_valid", 32'(ifid_valid), 32'd1);
      step();
      check("f1_instr", ifid_instr, 32'h4);
      check("f1_pc4", ifid_pc4, 32'h8);

      // Two-cycle stall at PC=0x10
      run_to(32'h10, "reach_10");
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) step();
      check("stall_addr", instr_addr, 32'h10);
      check("stall_instr", ifid_instr, 32'hC);
      check("stall_pc4", ifid_pc4, 32'h10);
      check("stall_state", 32'(fetch_state), 32'd2);
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("resume_instr", ifid_instr, 32'h10);

      // Redirect with misaligned target at PC=0x20
      run_to(32'h20, "reach_20");
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h103);
      step();
      check("redir_addr", instr_addr, 32'h100);
      check("redir_bubble", 32'(ifid_valid), 32'd0);
      check("redir_state", 32'(fetch_state), 32'd3);
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("redir_instr", ifid_instr, 32'h100);
      check("redir_pc4", ifid_pc4, 32'h104);
      check("redir_valid", 32'(ifid_valid), 32'd1);

      // Flush during a full stall at PC=0x40
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
      step();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step();
      check("flush_addr", instr_addr, 32'h40);
      check("flush_instr", ifid_instr, 32'h0);
      check("flush_valid", 32'(ifid_valid), 32'd0);

      // PC wrap at the top of the address space
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("wrap_addr", instr_addr, 32'h0);
      check("wrap_pc4", ifid_pc4, 32'h0);
      check("wrap_instr", ifid_instr, 32'hFFFF_FFFC);

      // Reset while in REDIRECT with a redirect still pending
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
      step();
      check("pre_rst_state", 32'(fetch_state), 32'd3);
      rst_n = 1'b0;
      step();
      check("mid_rst_addr", instr_addr, 32'h0);
      check("mid_rst_valid", 32'(ifid_valid), 32'd0);
      check("mid_rst_state", 32'(fetch_state), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("mid_rst_stall", stall_count, 32'h0);
      check("mid_rst_flush", flush_count, 32'h0);
      check("mid_rst_redir", redirect_count, 32'h0);
`endif
      rst_n = 1'b1;
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

      // Random traffic with a scrambled memory image
      scramble = 32'h1357_9BDF;
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), $urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode and of the hazard-detection block.
- Owns the program counter, drives the instruction-memory address, and captures instruction/PC+4 into IF/ID.
- Obeys stall (PCWrite, DecodeRegWrite), flush (FlushControl) and redirect (branch/jump target) from decode and hazard logic.
- Tracks a small state machine so a bubble is inserted cleanly after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word written into IF/ID on flush or bubble.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on rising Clk edge.
- PCWrite  input  1  1 = PC may advance/redirect; 0 = hold PC.
- DecodeRegWrite  input  1  1 = IF/ID may load; 0 = hold IF/ID.
- FlushControl  input  1  1 = load NOP_WORD/invalid into IF/ID this edge.
- Redirect  input  1  taken branch, jump or JR resolved in decode.
- RedirectTarget  input  32  next PC when Redirect is accepted; bits[1:0] ignored (forced 0).
- InstrAddr  output  32  instruction-memory address (= PC).
- InstrData  input  32  combinational instruction-memory read data for InstrAddr.
- IFID_Instruction  output  32  registered instruction to decode.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  1 = IFID_Instruction is a real fetched instruction.
- FetchState  output  2  current FSM state (debug/verification).

Behaviour:
- Reset (Reset==0 at edge): PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, state=BOOT, counters (if enabled)=0. Reset overrides every other input, including mid-stall or mid-redirect.
- States: BOOT=0, RUN=1, STALL=2, REDIRECT=3.
  - BOOT: one cycle after reset release. PC holds RESET_PC; IF/ID stays invalid; next state RUN.
  - RUN/STALL: normal operation; state shows STALL whenever PCWrite==0 in that cycle, else RUN.
  - REDIRECT: entered the cycle after an accepted redirect. Fetches from the new PC normally and returns to RUN/STALL by the same rules.
- PC update per edge (not BOOT), priority order:
  1. PCWrite==0: hold PC.
  2. Redirect==1: PC={RedirectTarget[31:2],2'b00}.
  3. Otherwise: PC=PC+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
- IF/ID update per edge (not BOOT), priority order:
  1. FlushControl==1: Instruction=NOP_WORD, PCPlus4=0, Valid=0. Applies even when DecodeRegWrite==0.
  2. DecodeRegWrite==0: hold all IF/ID fields.
  3. Redirect==1 && PCWrite==1: load bubble (NOP_WORD, Valid=0). The sequential fetch is on the wrong path.
  4. Otherwise: Instruction=InstrData, PCPlus4=PC+4, Valid=1.
- Simultaneous events:
  - PCWrite==0 with FlushControl==1: PC holds and IF/ID is bubbled (JR-wait case).
  - Redirect with PCWrite==0: redirect is ignored; requester must hold Redirect until accepted.
- Latency:
  - InstrAddr is combinational from the PC register.
  - An instruction appears on IF/ID one edge after its address is presented.
  - After an accepted redirect, the target instruction is valid in IF/ID two edges later, with exactly one bubble between.
- No combinational path from any input to IFID_* outputs.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined: adds outputs StallCount[31:0], FlushCount[31:0] and RedirectCount[31:0].
  - StallCount increments on each non-BOOT edge with PCWrite==0.
  - FlushCount increments on each non-BOOT edge with FlushControl==1.
  - RedirectCount increments on each accepted redirect.
  - All three saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset held low 3 cycles, then released, memory returns addr-as-data -> BOOT for 1 cycle with InstrAddr=0; then IF/ID gets {0x0,PC+4=4,Valid=1}, then {0x4,8,1}.
- PCWrite=0 and DecodeRegWrite=0 for 2 cycles at PC=0x10 -> InstrAddr stays 0x10 and IF/ID holds {0xC,0x10,1}; FetchState=STALL; resume fetches 0x10.
- Redirect=1, RedirectTarget=0x103 at PC=0x20 -> next InstrAddr=0x100; IF/ID Valid=0 for one cycle; following cycle IF/ID={mem[0x100],0x104,1}.
- FlushControl=1 with PCWrite=0 and DecodeRegWrite=0 at PC=0x40 -> PC stays 0x40; IF/ID becomes NOP_WORD, Valid=0.
- PC=0xFFFF_FFFC, no stall -> next InstrAddr=0x0000_0000; IF/ID PCPlus4=0x0000_0000.
- Reset asserted in the REDIRECT state -> next edge PC=RESET_PC, Valid=0, FetchState=BOOT. With FETCH_PERF_CNT_EN, all counters read 0.
